// File: rtl/fetch_pkg.sv
// Shared defaults and entry layout for the prefetching fetch stage.
// The entry struct matches the default widths; the top re-declares it for its own parameters.
package fetch_pkg;

    localparam int              FETCH_AW       = 8;
    localparam int              FETCH_IW       = 16;
    localparam int              FETCH_DEPTH    = 4;
    localparam logic [FETCH_AW-1:0] FETCH_RESET_PC = '0;

    typedef struct packed {
        logic [FETCH_AW-1:0] pc;
        logic [FETCH_IW-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH x W synchronous FIFO with push, pop and a dominant flush.
// The caller guarantees no push when full and no pop when empty.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 24
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    // NOTE: storage is reset along with the pointers so the head reads 0 out of
    // reset instead of X; with only DEPTH entries this is cheap and keeps the
    // consumer-facing outputs defined.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/fetch_prefetch.sv
// Fetch stage: owns the PC, issues sequential reads to a 1-cycle instruction
// memory and buffers returned words with their PC for a valid/ready consumer.
module fetch_prefetch
    import fetch_pkg::*;
#(
    parameter int             AW       = FETCH_AW,
    parameter int             IW       = FETCH_IW,
    parameter int             DEPTH    = FETCH_DEPTH,
    parameter logic [AW-1:0]  RESET_PC = AW'(FETCH_RESET_PC)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           fetch_en,
    output logic           mem_req,
    output logic [AW-1:0]  mem_addr,
    input  logic [IW-1:0]  mem_rdata,
    output logic           instr_valid,
    input  logic           instr_ready,
    output logic [IW-1:0]  instr_out,
    output logic [AW-1:0]  instr_pc,
    input  logic           redirect_valid,
    input  logic [AW-1:0]  redirect_pc
);

    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [IW-1:0] instr;
    } entry_t;

    logic [AW-1:0] pc;
    logic [AW-1:0] req_pc;
    logic          inflight;
    logic          kill;
    logic [CW-1:0] count;
    logic [CW-1:0] occupancy;
    logic          issue;
    logic          push;
    logic          pop;
    entry_t        wentry;
    entry_t        head;

    // Reserve a slot for the in-flight word so a return can never be dropped.
    assign occupancy = count + CW'(inflight);
    assign issue     = ~reset & fetch_en & ~redirect_valid & (occupancy < CW'(DEPTH));
    assign push      = inflight & ~kill & ~redirect_valid;
    assign pop       = instr_valid & instr_ready;
    assign wentry    = '{pc: req_pc, instr: mem_rdata};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc       <= RESET_PC;
            req_pc   <= '0;
            inflight <= 1'b0;
            kill     <= 1'b0;
        end else if (redirect_valid) begin
            pc       <= redirect_pc;
            inflight <= 1'b0;
            kill     <= 1'b1;
        end else begin
            kill     <= 1'b0;
            inflight <= issue;
            if (issue) begin
                pc     <= pc + AW'(1);
                req_pc <= pc;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(entry_t))
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (redirect_valid),
        .push  (push),
        .pop   (pop),
        .wdata (wentry),
        .rdata (head),
        .count (count)
    );

    assign mem_req     = issue;
    assign mem_addr    = pc;
    assign instr_valid = (count != '0) & ~redirect_valid;
    assign instr_out   = head.instr;
    assign instr_pc    = head.pc;

endmodule

// File: tb/tb_fetch_prefetch.sv
// Directed bench for fetch_prefetch: two instances (RESET_PC 0 and 8'hFE) share
// stimulus; each has a 1-cycle memory model returning 16'h1000 + address.
module tb_fetch_prefetch;

    logic        clk;
    logic        reset;
    logic        fetch_en;
    logic        instr_ready;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;

    logic        a_req,   b_req;
    logic [7:0]  a_addr,  b_addr;
    logic [15:0] a_rdata, b_rdata;
    logic        a_valid, b_valid;
    logic [15:0] a_out,   b_out;
    logic [7:0]  a_pc,    b_pc;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_prefetch #(.AW(8), .IW(16), .DEPTH(4), .RESET_PC(8'h00)) dut_a (
        .clk            (clk),
        .reset          (reset),
        .fetch_en       (fetch_en),
        .mem_req        (a_req),
        .mem_addr       (a_addr),
        .mem_rdata      (a_rdata),
        .instr_valid    (a_valid),
        .instr_ready    (instr_ready),
        .instr_out      (a_out),
        .instr_pc       (a_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    fetch_prefetch #(.AW(8), .IW(16), .DEPTH(4), .RESET_PC(8'hFE)) dut_b (
        .clk            (clk),
        .reset          (reset),
        .fetch_en       (fetch_en),
        .mem_req        (b_req),
        .mem_addr       (b_addr),
        .mem_rdata      (b_rdata),
        .instr_valid    (b_valid),
        .instr_ready    (instr_ready),
        .instr_out      (b_out),
        .instr_pc       (b_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        a_rdata <= 16'h1000 + {8'h00, a_addr};
        b_rdata <= 16'h1000 + {8'h00, b_addr};
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in cycle 0: the half-cycle after release, before the first edge.
    task automatic apply_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    initial begin
        logic [7:0]  exp_pc;
        logic [7:0]  eb;

        reset          = 1'b1;
        fetch_en       = 1'b1;
        instr_ready    = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 8'h00;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_req",   a_req,   0);
        check("rst_valid", a_valid, 0);
        check("rst_addr",  a_addr,  0);
        check("rst_out",   a_out,   0);
        check("rst_pc",    a_pc,    0);
        check("rst_addr_b", b_addr, 32'hFE);
        check("rst_req_b",  b_req,  0);

        // Test 1 / 4: free-running stream, and wrap on instance b
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("t1_req0",   a_req,   1);
        check("t1_addr0",  a_addr,  0);
        check("t1_valid0", a_valid, 0);
        for (int k = 1; k <= 8; k++) begin
            cyc();
            check("t1_req",   a_req,   1);
            check("t1_addr",  a_addr,  k);
            check("t1_valid", a_valid, (k >= 2) ? 1 : 0);
            if (k >= 2) begin
                check("t1_pc",  a_pc,  k - 2);
                check("t1_out", a_out, 32'h1000 + k - 2);
            end
            if (k >= 2 && k <= 5) begin
                eb = 8'hFE + 8'(k - 2);
                check("t4_valid", b_valid, 1);
                check("t4_pc",    b_pc,    {24'h0, eb});
                check("t4_out",   b_out,   {16'h0, 8'h10, eb});
            end
        end

        // Test 2: consumer stalled, queue fills to DEPTH, then drains in order
        instr_ready = 1'b0;
        apply_reset();
        for (int k = 0; k <= 5; k++) begin
            if (k > 0) cyc();
            check("t2_req", a_req, (k <= 3) ? 1 : 0);
            if (k >= 4) check("t2_addr_hold", a_addr, 4);
        end
        cyc();
        check("t2_full_req",   a_req,   0);
        check("t2_full_addr",  a_addr,  4);
        check("t2_full_valid", a_valid, 1);
        check("t2_full_pc",    a_pc,    0);
        instr_ready = 1'b1;
        for (int j = 0; j <= 5; j++) begin
            check("t2_valid", a_valid, 1);
            check("t2_pc",    a_pc,    j);
            check("t2_out",   a_out,   32'h1000 + j);
            if (j == 1) begin
                check("t2_resume_req",  a_req,  1);
                check("t2_resume_addr", a_addr, 4);
            end
            cyc();
        end

        // Test 3: redirect when pc=5
        apply_reset();
        repeat (5) cyc();
        check("t3_pre_addr", a_addr, 5);
        redirect_valid = 1'b1;
        redirect_pc    = 8'h40;
        #1;
        check("t3_n_req",   a_req,   0);
        check("t3_n_valid", a_valid, 0);
        cyc();
        redirect_valid = 1'b0;
        #1;
        check("t3_n1_req",   a_req,   1);
        check("t3_n1_addr",  a_addr,  32'h40);
        check("t3_n1_valid", a_valid, 0);
        cyc();
        check("t3_n2_valid", a_valid, 0);
        check("t3_n2_addr",  a_addr,  32'h41);
        cyc();
        check("t3_n3_valid", a_valid, 1);
        check("t3_n3_pc",    a_pc,    32'h40);
        check("t3_n3_out",   a_out,   32'h1040);
        cyc();
        check("t3_n4_pc",    a_pc,    32'h41);

        // Test 5: fetch_en low for three cycles mid-stream
        cyc();
        exp_pc = 8'h42;
        for (int i = 0; i < 12; i++) begin
            fetch_en = (i >= 3);
            #1;
            check("t5_req",   a_req,   (i >= 3) ? 1 : 0);
            check("t5_valid", a_valid, (i >= 2 && i <= 4) ? 0 : 1);
            if (a_valid) begin
                check("t5_pc",  a_pc,  {24'h0, exp_pc});
                check("t5_out", a_out, {16'h0, 8'h10, exp_pc});
                exp_pc = exp_pc + 8'd1;
            end
            cyc();
        end
        fetch_en = 1'b1;
        check("t5_delivered", {24'h0, exp_pc}, 32'h4B);

        // Test 6: async reset with three entries queued and a read in flight
        instr_ready = 1'b0;
        apply_reset();
        repeat (4) cyc();
        check("t6_pre_valid", a_valid, 1);
        check("t6_pre_req",   a_req,   0);
        #2;
        reset = 1'b1;
        #1;
        check("t6_valid", a_valid, 0);
        check("t6_req",   a_req,   0);
        check("t6_addr",  a_addr,  0);
        check("t6_pc",    a_pc,    0);
        check("t6_out",   a_out,   0);
        repeat (2) @(posedge clk);
        instr_ready = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("t6_c0_valid", a_valid, 0);
        check("t6_c0_req",   a_req,   1);
        cyc();
        check("t6_c1_valid", a_valid, 0);
        cyc();
        check("t6_c2_valid", a_valid, 1);
        check("t6_c2_pc",    a_pc,    0);
        check("t6_c2_out",   a_out,   32'h1000);
        cyc();
        check("t6_c3_pc",    a_pc,    1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
